// File: rtl/rggen_rtl_pkg.sv
// Shared helpers for the rggen RTL blocks: width clipping and AXI4-Lite
// response constants.
package rggen_rtl_pkg;

  localparam int RGGEN_AXI4LITE_RESP_WIDTH = 2;

  // A zero-width ID still needs one storage bit.
  function automatic int rggen_clip_width(input int width);
    return (width > 0) ? width : 1;
  endfunction

endpackage

// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bus bundle with master/slave views.
// Handshake: a beat transfers on a rising edge where valid && ready are both 1;
// valid never waits on ready, and payload is held stable while valid && !ready.
interface rggen_axi4lite_if #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  localparam int IDW = rggen_rtl_pkg::rggen_clip_width(ID_WIDTH);

  logic                     awvalid;
  logic                     awready;
  logic [IDW-1:0]           awid;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [IDW-1:0]           bid;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [IDW-1:0]           arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [IDW-1:0]           rid;
  logic [1:0]               rresp;
  logic [BUS_WIDTH-1:0]     rdata;

  modport master (
    output awvalid, awid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arprot,
    input  arready,
    input  rvalid, rid, rresp, rdata,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arprot,
    output arready,
    output rvalid, rid, rresp, rdata,
    input  rready
  );
endinterface

// File: rtl/rggen_axi4lite_response_slice.sv
// Two-entry (main + skid) register slice for one response channel.
// Payload reset is controlled by RGGEN_AXI4LITE_RESPONSE_BUFFER_DATA_RESET_EN.
module rggen_axi4lite_response_slice #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_push;
  logic             w_pop;
  logic             w_main_free;
  logic             w_main_load;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_main_next;

  assign o_ready = !r_skid_valid;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;

  assign w_push      = i_valid && o_ready;
  assign w_pop       = r_main_valid && i_ready;
  // Main can take a new entry when empty or being drained this cycle;
  // a waiting skid entry always has priority so ordering is preserved.
  assign w_main_free = !r_main_valid || w_pop;
  assign w_main_load = w_main_free && (r_skid_valid || w_push);
  assign w_skid_load = !w_main_free && w_push;
  assign w_main_next = r_skid_valid ? r_skid_data : i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_main_free) begin
        r_main_valid <= r_skid_valid || w_push;
      end
      if (r_skid_valid && w_pop) begin
        r_skid_valid <= 1'b0;
      end else if (w_skid_load) begin
        r_skid_valid <= 1'b1;
      end
    end
  end

`ifdef RGGEN_AXI4LITE_RESPONSE_BUFFER_DATA_RESET_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_main_load) begin
        r_main_data <= w_main_next;
      end
      if (w_skid_load) begin
        r_skid_data <= i_data;
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (w_main_load) begin
      r_main_data <= w_main_next;
    end
    if (w_skid_load) begin
      r_skid_data <= i_data;
    end
  end
`endif

endmodule

// File: rtl/rggen_axi4lite_response_buffer.sv
// AXI4-Lite response-path register slice: B and R fully registered, AW/W/AR
// passed straight through. Optional payload reset: RGGEN_AXI4LITE_RESPONSE_BUFFER_DATA_RESET_EN.
module rggen_axi4lite_response_buffer
  import rggen_rtl_pkg::*;
#(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  rggen_axi4lite_if.slave  slave_if,
  rggen_axi4lite_if.master master_if
);
  localparam int IDW = rggen_clip_width(ID_WIDTH);
  localparam int BW  = IDW + RGGEN_AXI4LITE_RESP_WIDTH;
  localparam int RW  = BW + BUS_WIDTH;

  logic [BW-1:0] w_b_in;
  logic [BW-1:0] w_b_out;
  logic [RW-1:0] w_r_in;
  logic [RW-1:0] w_r_out;

  assign master_if.awvalid = slave_if.awvalid;
  assign master_if.awid    = slave_if.awid;
  assign master_if.awaddr  = slave_if.awaddr;
  assign master_if.awprot  = slave_if.awprot;
  assign master_if.wvalid  = slave_if.wvalid;
  assign master_if.wdata   = slave_if.wdata;
  assign master_if.wstrb   = slave_if.wstrb;
  assign master_if.arvalid = slave_if.arvalid;
  assign master_if.arid    = slave_if.arid;
  assign master_if.araddr  = slave_if.araddr;
  assign master_if.arprot  = slave_if.arprot;
  assign slave_if.awready  = master_if.awready;
  assign slave_if.wready   = master_if.wready;
  assign slave_if.arready  = master_if.arready;

  assign w_b_in = {master_if.bid, master_if.bresp};
  assign {slave_if.bid, slave_if.bresp} = w_b_out;

  rggen_axi4lite_response_slice #(
    .WIDTH (BW)
  ) u_b_slice (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (master_if.bvalid),
    .o_ready (master_if.bready),
    .i_data  (w_b_in),
    .o_valid (slave_if.bvalid),
    .i_ready (slave_if.bready),
    .o_data  (w_b_out)
  );

  assign w_r_in = {master_if.rid, master_if.rresp, master_if.rdata};
  assign {slave_if.rid, slave_if.rresp, slave_if.rdata} = w_r_out;

  rggen_axi4lite_response_slice #(
    .WIDTH (RW)
  ) u_r_slice (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (master_if.rvalid),
    .o_ready (master_if.rready),
    .i_data  (w_r_in),
    .o_valid (slave_if.rvalid),
    .i_ready (slave_if.rready),
    .o_data  (w_r_out)
  );

endmodule

// File: tb/tb_rggen_axi4lite_response_buffer.sv
// Bench for rggen_axi4lite_response_buffer: directed sequences, pass-through
// vector table and randomized traffic against a queue-based response model.
module tb_rggen_axi4lite_response_buffer;
  localparam int IDW = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int BW  = IDW + 2;
  localparam int RW  = IDW + 2 + DW;

  logic clk;
  logic rst_n;

  rggen_axi4lite_if #(.ID_WIDTH(IDW), .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) up_if ();
  rggen_axi4lite_if #(.ID_WIDTH(IDW), .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) dn_if ();

  rggen_axi4lite_response_buffer #(
    .ID_WIDTH      (IDW),
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (DW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .slave_if  (up_if.slave),
    .master_if (dn_if.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: responses accepted but not yet delivered, oldest first
  logic [BW-1:0] b_q[$];
  logic [RW-1:0] r_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic           awvalid;
    logic [IDW-1:0] awid;
    logic [AW-1:0]  awaddr;
    logic [2:0]     awprot;
    logic           wvalid;
    logic [DW-1:0]  wdata;
    logic [3:0]     wstrb;
    logic           arvalid;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    logic [2:0]     arprot;
    logic [2:0]     rdy;
    logic [15:0]    exp_aw;
    logic [36:0]    exp_w;
    logic [15:0]    exp_ar;
    logic [2:0]     exp_rdy;
  } pt_vec_t;
  pt_vec_t pt_vec[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model step: deliver the head if the slave side accepts, then accept a new
  // response if fewer than two are held.
  task automatic model_update();
    logic b_in_ok;
    logic r_in_ok;
    b_in_ok = dn_if.bvalid && (b_q.size() < 2);
    r_in_ok = dn_if.rvalid && (r_q.size() < 2);
    if (b_q.size() > 0 && up_if.bready) void'(b_q.pop_front());
    if (r_q.size() > 0 && up_if.rready) void'(r_q.pop_front());
    if (b_in_ok) b_q.push_back({dn_if.bid, dn_if.bresp});
    if (r_in_ok) r_q.push_back({dn_if.rid, dn_if.rresp, dn_if.rdata});
  endtask

  task automatic model_check();
    chk("bvalid", 64'(up_if.bvalid), 64'(b_q.size() > 0));
    chk("bready", 64'(dn_if.bready), 64'(b_q.size() < 2));
    chk("rvalid", 64'(up_if.rvalid), 64'(r_q.size() > 0));
    chk("rready", 64'(dn_if.rready), 64'(r_q.size() < 2));
    if (b_q.size() > 0) chk("b_payload", 64'({up_if.bid, up_if.bresp}), 64'(b_q[0]));
    if (r_q.size() > 0) chk("r_payload", 64'({up_if.rid, up_if.rresp, up_if.rdata}), 64'(r_q[0]));
  endtask

  // One clock: model advances on the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  // driver tasks
  task automatic drive_b(input logic v, input logic [IDW-1:0] id, input logic [1:0] resp);
    dn_if.bvalid = v;
    dn_if.bid    = id;
    dn_if.bresp  = resp;
  endtask

  task automatic drive_r(input logic v, input logic [IDW-1:0] id, input logic [1:0] resp,
                         input logic [DW-1:0] data);
    dn_if.rvalid = v;
    dn_if.rid    = id;
    dn_if.rresp  = resp;
    dn_if.rdata  = data;
  endtask

  task automatic drive_pt(input pt_vec_t v);
    up_if.awvalid = v.awvalid;
    up_if.awid    = v.awid;
    up_if.awaddr  = v.awaddr;
    up_if.awprot  = v.awprot;
    up_if.wvalid  = v.wvalid;
    up_if.wdata   = v.wdata;
    up_if.wstrb   = v.wstrb;
    up_if.arvalid = v.arvalid;
    up_if.arid    = v.arid;
    up_if.araddr  = v.araddr;
    up_if.arprot  = v.arprot;
    {dn_if.awready, dn_if.wready, dn_if.arready} = v.rdy;
  endtask

  initial begin
    pt_vec_t z;
    z = '{default: '0};

    for (int i = 0; i < 8; i++) begin
      pt_vec[i].awvalid = 1'($urandom);
      pt_vec[i].awid    = IDW'($urandom);
      pt_vec[i].awaddr  = AW'($urandom);
      pt_vec[i].awprot  = 3'($urandom);
      pt_vec[i].wvalid  = 1'($urandom);
      pt_vec[i].wdata   = $urandom;
      pt_vec[i].wstrb   = 4'($urandom);
      pt_vec[i].arvalid = 1'($urandom);
      pt_vec[i].arid    = IDW'($urandom);
      pt_vec[i].araddr  = AW'($urandom);
      pt_vec[i].arprot  = 3'($urandom);
      pt_vec[i].rdy     = 3'(i);
      pt_vec[i].exp_aw  = {pt_vec[i].awvalid, pt_vec[i].awid, pt_vec[i].awaddr, pt_vec[i].awprot};
      pt_vec[i].exp_w   = {pt_vec[i].wvalid, pt_vec[i].wdata, pt_vec[i].wstrb};
      pt_vec[i].exp_ar  = {pt_vec[i].arvalid, pt_vec[i].arid, pt_vec[i].araddr, pt_vec[i].arprot};
      pt_vec[i].exp_rdy = 3'(i);
    end

    rst_n = 1'b0;
    drive_pt(z);
    drive_b(1'b0, '0, '0);
    drive_r(1'b0, '0, '0, '0);
    up_if.bready = 1'b1;
    up_if.rready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bvalid", 64'(up_if.bvalid), 64'd0);
    chk("rst_rvalid", 64'(up_if.rvalid), 64'd0);
    chk("rst_bready", 64'(dn_if.bready), 64'd1);
    chk("rst_rready", 64'(dn_if.rready), 64'd1);
`ifdef RGGEN_AXI4LITE_RESPONSE_BUFFER_DATA_RESET_EN
    chk("rst_rdata", 64'(up_if.rdata), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // single read
    drive_r(1'b1, 4'h3, 2'd0, 32'h1234_5678);
    tick();
    drive_r(1'b0, '0, '0, '0);
    chk("single_rvalid", 64'(up_if.rvalid), 64'd1);
    chk("single_rdata", 64'(up_if.rdata), 64'h1234_5678);
    chk("single_rid", 64'(up_if.rid), 64'h3);
    tick();
    chk("single_rvalid_after", 64'(up_if.rvalid), 64'd0);

    // streaming B
    for (int i = 0; i < 8; i++) begin
      drive_b(1'b1, IDW'(i), 2'(i));
      tick();
      chk("stream_bvalid", 64'(up_if.bvalid), 64'd1);
      chk("stream_bid", 64'(up_if.bid), 64'(i));
      chk("stream_bready", 64'(dn_if.bready), 64'd1);
    end
    drive_b(1'b0, '0, '0);
    tick();
    chk("stream_bvalid_end", 64'(up_if.bvalid), 64'd0);

    // backpressure on R
    up_if.rready = 1'b0;
    drive_r(1'b1, 4'h1, 2'd0, 32'hA);
    tick();
    chk("bp_rready_1", 64'(dn_if.rready), 64'd1);
    drive_r(1'b1, 4'h2, 2'd0, 32'hB);
    tick();
    drive_r(1'b0, '0, '0, '0);
    chk("bp_rready_low", 64'(dn_if.rready), 64'd0);
    chk("bp_hold_a", 64'(up_if.rdata), 64'hA);
    tick();
    chk("bp_still_a", 64'(up_if.rdata), 64'hA);
    up_if.rready = 1'b1;
    tick();
    chk("bp_deliver_b", 64'(up_if.rdata), 64'hB);
    chk("bp_rready_back", 64'(dn_if.rready), 64'd1);
    tick();
    chk("bp_empty", 64'(up_if.rvalid), 64'd0);

    // mid-operation reset with both entries of both channels full
    up_if.bready = 1'b0;
    up_if.rready = 1'b0;
    drive_b(1'b1, 4'h5, 2'd1);
    drive_r(1'b1, 4'h6, 2'd2, 32'hDEAD_0001);
    tick();
    drive_b(1'b1, 4'h7, 2'd3);
    drive_r(1'b1, 4'h8, 2'd1, 32'hDEAD_0002);
    tick();
    drive_b(1'b0, '0, '0);
    drive_r(1'b0, '0, '0, '0);
    chk("mr_full_bready", 64'(dn_if.bready), 64'd0);
    chk("mr_full_rready", 64'(dn_if.rready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_bvalid", 64'(up_if.bvalid), 64'd0);
    chk("mr_rvalid", 64'(up_if.rvalid), 64'd0);
    chk("mr_bready", 64'(dn_if.bready), 64'd1);
    chk("mr_rready", 64'(dn_if.rready), 64'd1);
    b_q.delete();
    r_q.delete();
    #1 rst_n = 1'b1;
    up_if.bready = 1'b1;
    up_if.rready = 1'b1;
    drive_r(1'b1, 4'h0, 2'd0, 32'h55);
    tick();
    drive_r(1'b0, '0, '0, '0);
    chk("mr_new_rvalid", 64'(up_if.rvalid), 64'd1);
    chk("mr_new_rdata", 64'(up_if.rdata), 64'h55);
    tick();
    chk("mr_alone", 64'(up_if.rvalid), 64'd0);
    chk("mr_b_idle", 64'(up_if.bvalid), 64'd0);

    // pass-through vectors
    for (int i = 0; i < 8; i++) begin
      drive_pt(pt_vec[i]);
      #1;
      chk("pt_aw", 64'({dn_if.awvalid, dn_if.awid, dn_if.awaddr, dn_if.awprot}), 64'(pt_vec[i].exp_aw));
      chk("pt_w", 64'({dn_if.wvalid, dn_if.wdata, dn_if.wstrb}), 64'(pt_vec[i].exp_w));
      chk("pt_ar", 64'({dn_if.arvalid, dn_if.arid, dn_if.araddr, dn_if.arprot}), 64'(pt_vec[i].exp_ar));
      chk("pt_rdy", 64'({up_if.awready, up_if.wready, up_if.arready}), 64'(pt_vec[i].exp_rdy));
      tick();
    end

    // randomized traffic on both channels plus pass-through
    for (int c = 0; c < 400; c++) begin
      pt_vec_t v;
      v = '{default: '0};
      v.awvalid = 1'($urandom);
      v.awaddr  = AW'($urandom);
      v.wdata   = $urandom;
      v.arvalid = 1'($urandom);
      v.araddr  = AW'($urandom);
      v.rdy     = 3'($urandom);
      drive_pt(v);
      drive_b(1'($urandom_range(0, 3) != 0), IDW'($urandom), 2'($urandom));
      drive_r(1'($urandom_range(0, 3) != 0), IDW'($urandom), 2'($urandom), $urandom);
      up_if.bready = 1'($urandom_range(0, 2) != 0);
      up_if.rready = 1'($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_pt_aw", 64'({dn_if.awvalid, dn_if.awaddr}), 64'({v.awvalid, v.awaddr}));
      chk("rnd_pt_rdy", 64'({up_if.awready, up_if.wready, up_if.arready}), 64'(v.rdy));
      tick();
    end

    // drain
    drive_b(1'b0, '0, '0);
    drive_r(1'b0, '0, '0, '0);
    up_if.bready = 1'b1;
    up_if.rready = 1'b1;
    repeat (3) tick();
    chk("drain_b", 64'(b_q.size()), 64'd0);
    chk("drain_r", 64'(r_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rggen_axi4lite_response_buffer.md
# rggen_axi4lite_response_buffer

Register slice for the AXI4-Lite response path: fully registers the write response (B) and read response (R) channels between an upstream bus master (`slave_if`) and the register block (`master_if`). AW, W and AR pass through combinationally. Placed in series with the request-side skid buffer, it removes every combinational path across the bridge. Each response channel is a two-entry (main + skid) pipeline register: full throughput, one cycle of latency.

## Interface
- `ID_WIDTH`, default 0: AXI ID width; storage width is `rggen_clip_width(ID_WIDTH)`.
- `ADDRESS_WIDTH`, default 8: address width, pass-through only.
- `BUS_WIDTH`, default 32: data width; `rdata` is BUS_WIDTH bits.
- `i_clk`  input  1  clock; the only clock; all state updates on its rising edge.
- `i_rst_n`  input  1  reset, asynchronous, active-low.
- `slave_if`  `rggen_axi4lite_if.slave`  upstream side; B/R driven from registers.
- `master_if`  `rggen_axi4lite_if.master`  register-block side; `bready`/`rready` driven from registers.

## Operation
- AW/W/AR pass-through: `master_if.{awvalid,awid,awaddr,awprot,wvalid,wdata,wstrb,arvalid,arid,araddr,arprot}` = the same `slave_if` signals; `slave_if.{awready,wready,arready}` = the same `master_if` signals.
- Per response channel (B payload {bid,bresp}; R payload {rid,rresp,rdata}) there are two states: main valid flag + payload, and skid valid flag + payload.
- Downstream side: `slave_if.xvalid` = main valid; `slave_if` payload = main payload.
- Upstream side: `master_if.xready` = !skid valid.
- push = `master_if.xvalid && master_if.xready`; pop = `slave_if.xvalid && slave_if.xready`.
- Next-state rules, per clock:
  - Main empty, push: payload -> main.
  - Main full, pop, skid empty, push: payload -> main (back-to-back).
  - Main full, pop, skid empty, no push: main empties.
  - Main full, no pop, push: payload -> skid; ready falls next cycle.
  - Main full, pop, skid full: skid -> main, skid empties. No push is possible because ready is low.
- Ordering strictly FIFO; no response dropped, duplicated or reordered.
- Payload held stable while `slave_if.xvalid && !slave_if.xready`, as AXI requires.

## Timing
- Reset values: `slave_if.bvalid`=0, `slave_if.rvalid`=0, `master_if.bready`=1, `master_if.rready`=1. Payload outputs: see Configuration.
- Latency: push at edge N gives `slave_if.xvalid`=1 from cycle N+1.
- Throughput: one response per cycle per channel while downstream ready stays high.
- Upstream ready falls the cycle after the skid fills. It rises the cycle after the skid drains into main.
- B and R are fully independent; simultaneous activity on both never interacts.
- Simultaneous push and pop with main full and skid empty: main is replaced, valid stays 1 with no bubble.
- Reset asserted mid-operation: both entries are discarded immediately and asynchronously, with valid flags at 0. Responses in flight are lost; the system resets both ends together.

## Configuration
- Macro `RGGEN_AXI4LITE_RESPONSE_BUFFER_DATA_RESET_EN`.
- Defined: payload registers (id, resp, rdata in both entries) reset asynchronously to 0. Payload outputs read 0 after reset.
- Undefined: payload registers have no reset and update only on load. Payload outputs are undefined until the first response. Valid flags are always reset.

## Structure
- `rggen_clip_width` comes from `rggen_rtl_pkg`. Add an `RGGEN_AXI4LITE_RESP_WIDTH` = 2 constant to `rggen_rtl_pkg`; no new typedefs.
- Sub-module `rggen_axi4lite_response_slice`:
  - Parameter `WIDTH`; ports `i_clk`, `i_rst_n`, `i_valid`, `o_ready`, `i_data[WIDTH]`, `o_valid`, `i_ready`, `o_data[WIDTH]`.
  - Holds the main/skid logic and honours the macro.
  - Instantiated twice: B with WIDTH = id+2, R with WIDTH = id+2+BUS_WIDTH. The top level packs and unpacks payloads.

## Test plan
- Reset: hold `i_rst_n`=0 -> bvalid=rvalid=0, bready=rready=1. With the macro defined, rdata=0.
- Single read: master rvalid for one cycle with rdata=0x1234_5678, rresp=0, slave rready=1 -> slave rvalid=1 exactly one cycle later with identical payload, then 0.
- Streaming: 8 back-to-back B responses with bid 0..7, slave bready=1 -> 8 consecutive bvalid cycles in order, no bubble, bready held 1.
- Backpressure: slave rready=0, master pushes rdata 0xA then 0xB -> rready drops after the second push. Raising slave rready delivers 0xA then 0xB on consecutive cycles, and rready returns to 1.
- Mid-operation reset: both entries full, pulse `i_rst_n` low between edges -> bvalid/rvalid fall immediately. After release, a new response 0x55 is delivered alone.
- Pass-through: drive AW/W/AR with random values and ready patterns -> outputs match inputs in the same cycle.
